// File: rtl/tof_dist_sq_gen_pkg.sv
// Shared beamforming definitions for the time-of-flight distance-squared feeder.
// Holds the default coordinate width, the distance-squared word width, its
// saturation value, the walker FSM state type and the saturating narrowing helper.
package tof_dist_sq_gen_pkg;

    localparam int COORD_W_DEF = 16;
    localparam int DIST_W      = 32;

    localparam logic [DIST_W-1:0] DIST_SAT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DX   = 3'd1,
        ST_SQ   = 3'd2,
        ST_SUM  = 3'd3,
        ST_HOLD = 3'd4,
        ST_DONE = 3'd5
    } tof_state_e;

    // Narrow a one-bit-wider sum to DIST_W bits, pinning to all-ones on carry out.
    function automatic logic [DIST_W-1:0] sat_dist(input logic [DIST_W:0] sum);
        logic [DIST_W-1:0] res;
        if (sum[DIST_W]) begin
            res = DIST_SAT;
        end else begin
            res = sum[DIST_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/tof_sq_unit.sv
// Registered unsigned squarer: clips its magnitude input to COORD_W bits and
// squares it into a 2*COORD_W-bit register. The result updates only when en
// is high and otherwise holds, so one instance can keep a per-focal-point value.
module tof_sq_unit
    import tof_dist_sq_gen_pkg::*;
#(
    parameter int IN_W    = COORD_W_DEF,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [IN_W-1:0]        mag,
    output logic [2*COORD_W-1:0]   sq
);

    localparam int SQ_W = 2 * COORD_W;

    logic [COORD_W-1:0] clip_s;
    logic [SQ_W-1:0]    sq_r;

    generate
        if (IN_W > COORD_W) begin : g_clip
            localparam logic [IN_W-1:0] MAG_MAX = {{(IN_W-COORD_W){1'b0}}, {COORD_W{1'b1}}};
            // Saturate magnitudes wider than the coordinate span before squaring
            always_comb begin
                if (mag > MAG_MAX) begin
                    clip_s = {COORD_W{1'b1}};
                end else begin
                    clip_s = mag[COORD_W-1:0];
                end
            end
        end else begin : g_pass
            assign clip_s = mag;
        end
    endgenerate

    // Square register: loads on enable, holds otherwise, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sq_r <= {SQ_W{1'b0}};
        end else if (en) begin
            sq_r <= SQ_W'(clip_s) * SQ_W'(clip_s);
        end else begin
            sq_r <= sq_r;
        end
    end

    assign sq = sq_r;

endmodule

// File: rtl/tof_dist_sq_gen.sv
// Distance-squared generator for one focal point: walks N_ELEM transducer
// elements and emits (x_f - x_e)^2 + z_f^2 per element over valid/ready,
// with the element index alongside, saturating at 32'hFFFF_FFFF.
// Optional build macro DIST_SQ_APERTURE_EN adds aperture_half; elements whose
// clipped |dx| exceeds it are skipped silently.
module tof_dist_sq_gen
    import tof_dist_sq_gen_pkg::*;
#(
    parameter int N_ELEM  = 64,
    parameter int COORD_W = COORD_W_DEF,
    parameter int IDX_W   = $clog2(N_ELEM)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic signed [COORD_W-1:0]  focus_x,
    input  logic signed [COORD_W-1:0]  focus_z,
    input  logic signed [COORD_W-1:0]  elem_x0,
    input  logic signed [COORD_W-1:0]  elem_pitch,
`ifdef DIST_SQ_APERTURE_EN
    input  logic [COORD_W-1:0]         aperture_half,
`endif
    output logic [DIST_W-1:0]          dist_sq,
    output logic [IDX_W-1:0]           elem_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done
);

    // Element position accumulator is wide enough that no legal walk wraps;
    // the lateral offset gets one more bit so the subtraction cannot overflow.
    localparam int ACC_W = COORD_W + IDX_W + 1;
    localparam int DXW   = ACC_W + 1;
    localparam int SQ_W  = 2 * COORD_W;
    localparam int SUM_W = DIST_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [DXW-1:0]   DX_ONE   = {{(DXW-1){1'b0}}, 1'b1};
    localparam logic [COORD_W-1:0] CRD_ONE = {{(COORD_W-1){1'b0}}, 1'b1};
    localparam logic [DXW-1:0]   CLIP_MAX = {{(DXW-COORD_W){1'b0}}, {COORD_W{1'b1}}};

    tof_state_e state_r;
    tof_state_e state_nxt_s;

    logic [COORD_W-1:0] focus_x_r;
    logic [COORD_W-1:0] focus_z_r;
    logic [COORD_W-1:0] pitch_r;
    logic [ACC_W-1:0]   elem_x_r;
    logic [IDX_W-1:0]   idx_r;
    logic [COORD_W-1:0] absdx_r;
    logic               zsq_pend_r;
    logic [DIST_W-1:0]  dist_sq_r;
    logic [IDX_W-1:0]   elem_idx_r;
    logic               out_valid_r;
    logic               busy_r;
    logic               done_r;

    logic [DXW-1:0]     fx_ext_s;
    logic [DXW-1:0]     ex_ext_s;
    logic [ACC_W-1:0]   x0_ext_s;
    logic [ACC_W-1:0]   pitch_ext_s;
    logic [DXW-1:0]     dx_s;
    logic [DXW-1:0]     dx_mag_s;
    logic [COORD_W-1:0] absdx_clip_s;
    logic [COORD_W-1:0] abs_fz_s;
    logic [SQ_W-1:0]    z_sq_s;
    logic [SQ_W-1:0]    dx_sq_s;
    logic [SUM_W-1:0]   sum_s;
    logic               last_s;
    logic               skip_s;
    logic               advance_s;

    // Saturate an offset magnitude to the largest coordinate span
    function automatic logic [COORD_W-1:0] clip_mag(input logic [DXW-1:0] m);
        logic [COORD_W-1:0] c;
        if (m > CLIP_MAX) begin
            c = {COORD_W{1'b1}};
        end else begin
            c = m[COORD_W-1:0];
        end
        return c;
    endfunction

    assign fx_ext_s    = {{(DXW-COORD_W){focus_x_r[COORD_W-1]}}, focus_x_r};
    assign ex_ext_s    = {elem_x_r[ACC_W-1], elem_x_r};
    assign x0_ext_s    = {{(ACC_W-COORD_W){elem_x0[COORD_W-1]}}, elem_x0};
    assign pitch_ext_s = {{(ACC_W-COORD_W){pitch_r[COORD_W-1]}}, pitch_r};
    assign last_s      = (idx_r == LAST_IDX);

    // Lateral offset to the current element, its magnitude and clipped magnitude
    always_comb begin
        dx_s = fx_ext_s - ex_ext_s;
        if (dx_s[DXW-1]) begin
            dx_mag_s = ~dx_s + DX_ONE;
        end else begin
            dx_mag_s = dx_s;
        end
        absdx_clip_s = clip_mag(dx_mag_s);
    end

    // Depth magnitude; the most negative coordinate still fits as unsigned
    always_comb begin
        if (focus_z_r[COORD_W-1]) begin
            abs_fz_s = ~focus_z_r + CRD_ONE;
        end else begin
            abs_fz_s = focus_z_r;
        end
    end

    // Aperture gate: decides in SQ whether this element is dropped
    always_comb begin
`ifdef DIST_SQ_APERTURE_EN
        if (absdx_r > aperture_half) begin
            skip_s = 1'b1;
        end else begin
            skip_s = 1'b0;
        end
`else
        skip_s = 1'b0;
`endif
    end

    // Step to the next element on a consumer accept or an aperture skip
    always_comb begin
        if ((state_r == ST_HOLD) && out_ready) begin
            advance_s = 1'b1;
        end else if ((state_r == ST_SQ) && skip_s) begin
            advance_s = 1'b1;
        end else begin
            advance_s = 1'b0;
        end
    end

    assign sum_s = SUM_W'(dx_sq_s) + SUM_W'(z_sq_s);

    // z^2 is loaded once per focal point, during the first DX cycle
    tof_sq_unit #(
        .IN_W    (COORD_W),
        .COORD_W (COORD_W)
    ) u_z_sq (
        .clk   (clk),
        .reset (reset),
        .en    ((state_r == ST_DX) && zsq_pend_r),
        .mag   (abs_fz_s),
        .sq    (z_sq_s)
    );

    // dx^2 is recomputed for each element in SQ
    tof_sq_unit #(
        .IN_W    (COORD_W),
        .COORD_W (COORD_W)
    ) u_dx_sq (
        .clk   (clk),
        .reset (reset),
        .en    (state_r == ST_SQ),
        .mag   (absdx_r),
        .sq    (dx_sq_s)
    );

    // Walker next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_DX;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DX: begin
                state_nxt_s = ST_SQ;
            end
            ST_SQ: begin
                if (skip_s) begin
                    if (last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_DX;
                    end
                end else begin
                    state_nxt_s = ST_SUM;
                end
            end
            ST_SUM: begin
                state_nxt_s = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_DX;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Walker state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers, updated per walker state
    always_ff @(posedge clk) begin
        if (reset) begin
            focus_x_r   <= {COORD_W{1'b0}};
            focus_z_r   <= {COORD_W{1'b0}};
            pitch_r     <= {COORD_W{1'b0}};
            elem_x_r    <= {ACC_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            absdx_r     <= {COORD_W{1'b0}};
            zsq_pend_r  <= 1'b0;
            dist_sq_r   <= {DIST_W{1'b0}};
            elem_idx_r  <= {IDX_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        focus_x_r  <= focus_x;
                        focus_z_r  <= focus_z;
                        pitch_r    <= elem_pitch;
                        elem_x_r   <= x0_ext_s;
                        idx_r      <= {IDX_W{1'b0}};
                        zsq_pend_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                ST_DX: begin
                    absdx_r    <= absdx_clip_s;
                    zsq_pend_r <= 1'b0;
                end
                ST_SQ: begin
                    absdx_r <= absdx_r;
                end
                ST_SUM: begin
                    dist_sq_r   <= sat_dist(sum_s);
                    elem_idx_r  <= idx_r;
                    out_valid_r <= 1'b1;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
            if (advance_s && !last_s) begin
                idx_r    <= idx_r + IDX_ONE;
                elem_x_r <= elem_x_r + pitch_ext_s;
            end
        end
    end

    assign dist_sq   = dist_sq_r;
    assign elem_idx  = elem_idx_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_tof_dist_sq_gen.sv
// Self-checking bench for tof_dist_sq_gen with a 4-element walk. Expected
// results come from a behavioural distance model and are queued as each focal
// point is started, then popped as the DUT hands results over.
module tb_tof_dist_sq_gen;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int IW = $clog2(N);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic signed [CW-1:0]  focus_x;
    logic signed [CW-1:0]  focus_z;
    logic signed [CW-1:0]  elem_x0;
    logic signed [CW-1:0]  elem_pitch;
    logic [31:0]           dist_sq;
    logic [IW-1:0]         elem_idx;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;
`ifdef DIST_SQ_APERTURE_EN
    logic [CW-1:0]         aperture_half;
`endif

    typedef struct {
        logic [31:0] d;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tof_dist_sq_gen #(
        .N_ELEM  (N),
        .COORD_W (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .focus_x       (focus_x),
        .focus_z       (focus_z),
        .elem_x0       (elem_x0),
        .elem_pitch    (elem_pitch),
`ifdef DIST_SQ_APERTURE_EN
        .aperture_half (aperture_half),
`endif
        .dist_sq       (dist_sq),
        .elem_idx      (elem_idx),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done)
    );

    // Behavioural squared distance with |dx| clip and 32-bit saturation
    function automatic logic [31:0] model_dist(input int fx, input int fz, input int x0,
                                               input int pitch, input int i);
        longint ex, dx, a, d;
        logic [63:0] dv;
        ex = longint'(x0) + longint'(i) * longint'(pitch);
        dx = longint'(fx) - ex;
        a  = (dx < 0) ? -dx : dx;
        if (a > 65535) a = 65535;
        d  = a * a + longint'(fz) * longint'(fz);
        if (d > 64'sd4294967295) return 32'hFFFF_FFFF;
        dv = 64'(d);
        return dv[31:0];
    endfunction

    task automatic push_run(input int fx, input int fz, input int x0, input int pitch, input int lo);
        exp_t e;
        for (int i = lo; i < N; i++) begin
            e.d   = model_dist(fx, fz, x0, pitch, i);
            e.idx = i;
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input int fx, input int fz, input int x0, input int pitch);
        @(negedge clk);
        focus_x    = 16'(fx);
        focus_z    = 16'(fz);
        elem_x0    = 16'(x0);
        elem_pitch = 16'(pitch);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Scoreboard consumer: pops on each handshake, checks stalls, gaps and done
    task automatic drain(input int stall_idx, input int stall_len, input bit poke_mid,
                         input bit poke_done, input bit check_gap, output int first_lat);
        int   cyc, exp_done, last_acc, stalled;
        bit   prev_valid, poked, finished;
        exp_t e;
        cyc = 0; exp_done = -1; last_acc = -1; stalled = 0;
        prev_valid = 1'b0; poked = 1'b0; finished = 1'b0; first_lat = -1;
        while (!finished && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start     = 1'b0;
            out_ready = 1'b1;
            if (out_valid && !prev_valid) begin
                if (first_lat < 0) begin
                    first_lat = cyc;
                end else if (check_gap) begin
                    total++;
                    if ((cyc - last_acc) !== 4) begin
                        bad++;
                        $display("FAIL gap: got %0d cycles want 4 (idx %0d)", cyc - last_acc, elem_idx);
                    end
                end
            end
            prev_valid = out_valid;
            if (poke_mid && !poked && out_valid && elem_idx == 2'd2) begin
                start   = 1'b1;
                focus_x = 16'sd1000;
                focus_z = 16'sd0;
                poked   = 1'b1;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_out: got idx %0d dist %0d want no output", elem_idx, dist_sq);
                end else if (int'(elem_idx) == stall_idx && stalled < stall_len) begin
                    out_ready = 1'b0;
                    stalled++;
                    total++;
                    if (dist_sq !== exp_q[0].d || int'(elem_idx) !== exp_q[0].idx) begin
                        bad++;
                        $display("FAIL stall_hold: got %0d/%0d want %0d/%0d", dist_sq, elem_idx,
                                 exp_q[0].d, exp_q[0].idx);
                    end
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (dist_sq !== e.d || int'(elem_idx) !== e.idx) begin
                        bad++;
                        $display("FAIL dist: got %0d idx %0d want %0d idx %0d", dist_sq, elem_idx, e.d, e.idx);
                    end
                    last_acc = cyc;
                    if (exp_q.size() == 0) exp_done = cyc + 1;
                end
            end
            if (cyc == exp_done) begin
                total++;
                if (done !== 1'b1 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL done_pulse: got done=%0b busy=%0b want 1/1", done, busy);
                end
                if (poke_done) start = 1'b1;
            end else if (done !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL stray_done: got done=%0b at cycle %0d want 0", done, cyc);
            end
            if (exp_done > 0 && cyc == exp_done + 1) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_clear: got %0b want 0", busy);
                end
                finished = 1'b1;
            end
        end
        if (!finished) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d results left want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total += 5;
        if (dist_sq !== 32'd0)   begin bad++; $display("FAIL rst_dist: got %0d want 0", dist_sq); end
        if (elem_idx !== 2'd0)   begin bad++; $display("FAIL rst_idx: got %0d want 0", elem_idx); end
        if (out_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
        if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        if (done !== 1'b0)       begin bad++; $display("FAIL rst_done: got %0b want 0", done); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int lat;
        push_run(0, 100, -3, 1, 0);
        pulse_start(0, 100, -3, 1);
        drain(-1, 0, 1'b0, 1'b0, 1'b1, lat);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL latency: got %0d want 3", lat); end
    endtask

    task automatic test_saturate;
        int lat;
        push_run(32767, 32767, -32768, 0, 0);
        pulse_start(32767, 32767, -32768, 0);
        drain(-1, 0, 1'b0, 1'b0, 1'b1, lat);
        push_run(32767, 0, -32768, -100, 0);
        pulse_start(32767, 0, -32768, -100);
        drain(-1, 0, 1'b0, 1'b0, 1'b1, lat);
    endtask

    task automatic test_stall;
        int lat;
        push_run(-500, -1234, 200, 37, 0);
        pulse_start(-500, -1234, 200, 37);
        drain(1, 5, 1'b0, 1'b0, 1'b1, lat);
    endtask

    task automatic test_start_ignored;
        int lat;
        bit leak;
        push_run(0, 100, -3, 1, 0);
        pulse_start(0, 100, -3, 1);
        drain(-1, 0, 1'b1, 1'b1, 1'b1, lat);
        leak = 1'b0;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid || busy || done) leak = 1'b1;
        end
        total++;
        if (leak) begin bad++; $display("FAIL done_start: got activity after ignored start want idle"); end
        push_run(-7, -20, 5, -3, 0);
        pulse_start(-7, -20, 5, -3);
        drain(-1, 0, 1'b0, 1'b0, 1'b1, lat);
    endtask

    task automatic test_reset_mid;
        int  cnt, lat;
        bit  seen, leak;
        pulse_start(0, 100, -3, 1);
        seen = 1'b0;
        cnt  = 0;
        while (!seen && cnt < 10) begin
            @(negedge clk);
            cnt++;
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (!seen || elem_idx !== 2'd0 || dist_sq !== model_dist(0, 100, -3, 1, 0)) begin
            bad++;
            $display("FAIL mid_first: got valid=%0b %0d/%0d want 1 10009/0", seen, dist_sq, elem_idx);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got v=%0b b=%0b d=%0b want 0/0/0", out_valid, busy, done);
        end
        leak = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || busy || done) leak = 1'b1;
        end
        total++;
        if (leak) begin bad++; $display("FAIL mid_quiet: got activity after reset want idle"); end
        push_run(0, 100, -3, 1, 0);
        pulse_start(0, 100, -3, 1);
        drain(-1, 0, 1'b0, 1'b0, 1'b1, lat);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL mid_latency: got %0d want 3", lat); end
    endtask

    task automatic test_random;
        int fx, fz, x0, pitch, lat;
        for (int r = 0; r < 4; r++) begin
            fx    = int'($urandom_range(65535)) - 32768;
            fz    = int'($urandom_range(65535)) - 32768;
            x0    = int'($urandom_range(65535)) - 32768;
            pitch = int'($urandom_range(65535)) - 32768;
            push_run(fx, fz, x0, pitch, 0);
            pulse_start(fx, fz, x0, pitch);
            drain(-1, 0, 1'b0, 1'b0, 1'b1, lat);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        push_run(10, 3, 8, 1, 0);
        pulse_start(10, 3, 8, 1);
        drain(-1, 0, 1'b0, 1'b0, 1'b1, lat);
        push_run(-10, -3, -8, -1, 0);
        pulse_start(-10, -3, -8, -1);
        drain(2, 2, 1'b0, 1'b0, 1'b1, lat);
    endtask

`ifdef DIST_SQ_APERTURE_EN
    task automatic test_aperture;
        int lat;
        aperture_half = 16'd1;
        push_run(0, 100, -3, 1, 2);
        pulse_start(0, 100, -3, 1);
        drain(-1, 0, 1'b0, 1'b0, 1'b0, lat);
        aperture_half = 16'hFFFF;
    endtask
`endif

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        focus_x    = 16'sd0;
        focus_z    = 16'sd0;
        elem_x0    = 16'sd0;
        elem_pitch = 16'sd0;
        out_ready  = 1'b1;
`ifdef DIST_SQ_APERTURE_EN
        aperture_half = 16'hFFFF;
`endif
        test_reset();
        test_basic();
        test_saturate();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_back_to_back();
`ifdef DIST_SQ_APERTURE_EN
        test_aperture();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
